// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: NRD combinational read ports, two writeback
// lanes with write-to-read bypass, and a per-register busy scoreboard.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*XLEN-1:0]     wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    output logic [NREGS-1:0]      busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [AW-1:0]    wa [2];
    logic [XLEN-1:0]  wd [2];
    logic [AW-1:0]    ra [NRD];

    logic [NREGS-1:0] hit0_vec;
    logic [NREGS-1:0] hit1_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        for (int unsigned l = 0; l < 2; l++) begin
            wa[l] = wr_addr[l*AW +: AW];
            wd[l] = wr_data[l*XLEN +: XLEN];
        end
        for (int unsigned k = 0; k < NRD; k++) begin
            ra[k] = rd_addr[k*AW +: AW];
        end
    end

    // One-hot decode of both write lanes and the issue port; register 0 is
    // masked out entirely when hardwired to zero.
    always_comb begin
        hit0_vec = '0;
        hit1_vec = '0;
        set_vec  = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            hit0_vec[r] = wr_en[0] && (wa[0] == AW'(r));
            hit1_vec[r] = wr_en[1] && (wa[1] == AW'(r));
            set_vec[r]  = issue_en && (issue_addr == AW'(r));
        end
        if (ZR) begin
            hit0_vec[0] = 1'b0;
            hit1_vec[0] = 1'b0;
            set_vec[0]  = 1'b0;
        end
        clr_vec = hit0_vec | hit1_vec;
    end

    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (hit1_vec[r]) begin
                regs_d[r] = wd[1];
            end else if (hit0_vec[r]) begin
                regs_d[r] = wd[0];
            end else begin
                regs_d[r] = regs_q[r];
            end
        end
        // A new producer supersedes a retiring one on the same register.
        busy_d = set_vec | (busy_q & ~clr_vec);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Lane 1 bypass outranks lane 0, matching the write-port priority.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            if (ZR && (ra[k] == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (wr_en[1] && (wa[1] == ra[k])) begin
                rd_data[k*XLEN +: XLEN] = wd[1];
            end else if (wr_en[0] && (wa[0] == ra[k])) begin
                rd_data[k*XLEN +: XLEN] = wd[0];
            end else begin
                rd_data[k*XLEN +: XLEN] = regs_q[ra[k]];
            end
            rd_busy[k] = busy_q[ra[k]] & ~clr_vec[ra[k]];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: default, ZERO_REG=0 and wide/4-port
// instances, directed scenarios plus a randomised run against a behavioural model.
module tb_regfile_mp_sb;

    localparam int AW  = 5;
    localparam int XL  = 32;
    localparam int AWC = 4;
    localparam int XLC = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared stimulus for instances A (ZERO_REG=1) and B (ZERO_REG=0)
    logic [2*AW-1:0]  rd_addr;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*XL-1:0]  wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;

    logic [2*XL-1:0]  a_rd_data, b_rd_data;
    logic [1:0]       a_rd_busy, b_rd_busy;
    logic [31:0]      a_busy_vec, b_busy_vec;

    logic [4*AWC-1:0] c_rd_addr;
    logic [4*XLC-1:0] c_rd_data;
    logic [3:0]       c_rd_busy;
    logic [1:0]       c_wr_en;
    logic [2*AWC-1:0] c_wr_addr;
    logic [2*XLC-1:0] c_wr_data;
    logic             c_issue_en;
    logic [AWC-1:0]   c_issue_addr;
    logic [15:0]      c_busy_vec;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_a (
        .clock(clk), .reset_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(0)) u_b (
        .clock(clk), .reset_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(b_busy_vec)
    );

    regfile_mp_sb #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1)) u_c (
        .clock(clk), .reset_n(rst_n), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .issue_en(c_issue_en), .issue_addr(c_issue_addr), .busy_vec(c_busy_vec)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare_next(input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;
        c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_issue_en = 1'b0; c_issue_addr = '0;
    endtask

    task automatic wr(input int l, input int a, input logic [31:0] d);
        wr_en[l] = 1'b1;
        wr_addr[l*AW +: AW] = AW'(a);
        wr_data[l*XL +: XL] = d;
    endtask

    task automatic issue(input int a);
        issue_en = 1'b1;
        issue_addr = AW'(a);
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic c_wr(input int l, input int a, input logic [63:0] d);
        c_wr_en[l] = 1'b1;
        c_wr_addr[l*AWC +: AWC] = AWC'(a);
        c_wr_data[l*XLC +: XLC] = d;
    endtask

    task automatic c_set_rd(input int k, input int a);
        c_rd_addr[k*AWC +: AWC] = AWC'(a);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
        if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
        return m_regs[a];
    endfunction

    function automatic logic m_rdbusy(input logic [4:0] a);
        return m_busy[a] && !((wr_en[0] && wr_addr[4:0] == a) || (wr_en[1] && wr_addr[9:5] == a));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] P3 = 64'hA5A5_0000_FFFF_5A5A;
    localparam logic [63:0] P4 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] P5 = 64'hDEAD_BEEF_CAFE_F00D;

    initial begin
        rst_n = 1'b0;
        rd_addr = '0;
        c_rd_addr = '0;
        idle();

        // Inside reset: bypass still visible, writes/issue ignored
        @(negedge clk);
        set_rd(0, 5); set_rd(1, 7);
        wr(0, 5, 32'h55); issue(7);
        expect_val("rst_bypass", 64'h55);
        expect_val("rst_rd_busy", 64'd0);
        expect_val("rst_busy_vec", 64'd0);
        expect_val("rst_r7", 64'd0);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_rd_busy);
        compare_next(a_busy_vec);
        compare_next(a_rd_data[63:32]);
        @(negedge clk);
        idle(); rst_n = 1'b1;
        @(negedge clk);
        expect_val("rst_wr_ignored", 64'd0);
        expect_val("rst_issue_ignored", 64'd0);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_busy_vec);

        // Asynchronous reset mid-cycle
        @(negedge clk);
        wr(0, 5, 32'hDEADBEEF); issue(7);
        @(negedge clk);
        idle();
        expect_val("pre_rst_r5", 64'hDEADBEEF);
        expect_val("pre_rst_busy7", 64'd1);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_busy_vec[7]);
        #1 rst_n = 1'b0;
        expect_val("async_rst_r5", 64'd0);
        expect_val("async_rst_bvec", 64'd0);
        expect_val("async_rst_rdbusy", 64'd0);
        #1;
        compare_next(a_rd_data[31:0]);
        compare_next(a_busy_vec);
        compare_next(a_rd_busy);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_val("post_rst_r5", 64'd0);
        #2;
        compare_next(a_rd_data[31:0]);

        // Bypass priority
        @(negedge clk);
        set_rd(0, 3); set_rd(1, 3);
        wr(0, 3, 32'h1111); wr(1, 3, 32'h2222);
        expect_val("byp_dual_p0", 64'h2222);
        expect_val("byp_dual_p1", 64'h2222);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_rd_data[63:32]);
        @(negedge clk);
        idle();
        expect_val("dual_commit_r3", 64'h2222);
        #2;
        compare_next(a_rd_data[31:0]);
        @(negedge clk);
        wr(0, 3, 32'h1111);
        expect_val("byp_lane0", 64'h1111);
        #2;
        compare_next(a_rd_data[31:0]);
        @(negedge clk);
        idle();
        set_rd(0, 4); set_rd(1, 6);
        wr(0, 4, 32'hAAAA); wr(1, 6, 32'hBBBB);
        expect_val("byp_split_p0", 64'hAAAA);
        expect_val("byp_split_p1", 64'hBBBB);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_rd_data[63:32]);
        @(negedge clk);
        idle(); set_rd(1, 3);
        expect_val("split_commit_r4", 64'hAAAA);
        expect_val("lane0_commit_r3", 64'h1111);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_rd_data[63:32]);

        // Zero register, ZERO_REG=1 (A) versus ZERO_REG=0 (B)
        @(negedge clk);
        set_rd(0, 0); set_rd(1, 0);
        wr(0, 0, 32'hFFFFFFFF); issue(0);
        expect_val("zr_a_p0", 64'd0);
        expect_val("zr_a_p1", 64'd0);
        expect_val("zr_b_bypass", 64'hFFFFFFFF);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_rd_data[63:32]);
        compare_next(b_rd_data[31:0]);
        @(negedge clk);
        idle();
        expect_val("zr_a_r0", 64'd0);
        expect_val("zr_a_busy0", 64'd0);
        expect_val("zr_b_r0", 64'hFFFFFFFF);
        expect_val("zr_b_busy0", 64'd1);
        expect_val("zr_b_rdbusy", 64'd1);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(a_busy_vec[0]);
        compare_next(b_rd_data[31:0]);
        compare_next(b_busy_vec[0]);
        compare_next(b_rd_busy[0]);
        @(negedge clk);
        wr(1, 0, 32'h1234);
        expect_val("zr_a_lane1", 64'd0);
        expect_val("zr_b_lane1_byp", 64'h1234);
        expect_val("zr_b_retire_rdbusy", 64'd0);
        #2;
        compare_next(a_rd_data[31:0]);
        compare_next(b_rd_data[31:0]);
        compare_next(b_rd_busy[0]);
        @(negedge clk);
        idle();
        expect_val("zr_b_cleared", 64'd0);
        expect_val("zr_b_r0_final", 64'h1234);
        #2;
        compare_next(b_busy_vec[0]);
        compare_next(b_rd_data[31:0]);

        // Scoreboard set/clear timing on r9
        @(negedge clk);
        set_rd(0, 9); set_rd(1, 9);
        issue(9);
        expect_val("sb_issue_rdbusy", 64'd0);
        expect_val("sb_issue_bvec", 64'd0);
        #2;
        compare_next(a_rd_busy[0]);
        compare_next(a_busy_vec[9]);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            idle();
            expect_val("sb_busy_bvec", 64'd1);
            expect_val("sb_busy_rdbusy", 64'd1);
            #2;
            compare_next(a_busy_vec[9]);
            compare_next(a_rd_busy[0]);
        end
        @(negedge clk);
        wr(0, 9, 32'h42);
        expect_val("sb_retire_rdbusy", 64'd0);
        expect_val("sb_retire_data", 64'h42);
        expect_val("sb_retire_bvec", 64'd1);
        #2;
        compare_next(a_rd_busy[0]);
        compare_next(a_rd_data[31:0]);
        compare_next(a_busy_vec[9]);
        @(negedge clk);
        idle();
        expect_val("sb_cleared_bvec", 64'd0);
        expect_val("sb_cleared_data", 64'h42);
        #2;
        compare_next(a_busy_vec[9]);
        compare_next(a_rd_data[31:0]);
        @(negedge clk);
        issue(9); wr(1, 9, 32'h77);
        @(negedge clk);
        idle();
        expect_val("sb_set_wins", 64'd1);
        expect_val("sb_set_wins_data", 64'h77);
        #2;
        compare_next(a_busy_vec[9]);
        compare_next(a_rd_data[31:0]);
        @(negedge clk);
        issue(9);
        @(negedge clk);
        idle();
        expect_val("sb_reissue", 64'd1);
        #2;
        compare_next(a_busy_vec[9]);
        @(negedge clk);
        wr(1, 9, 32'h88);
        @(negedge clk);
        idle();
        expect_val("sb_single_clear", 64'd0);
        #2;
        compare_next(a_busy_vec[9]);

        // Wide, four-port instance
        @(negedge clk);
        c_wr(0, 1, P1); c_wr(1, 2, P2); c_issue_en = 1'b1; c_issue_addr = 4'd3;
        @(negedge clk);
        idle();
        c_wr(0, 3, P3); c_wr(1, 4, P4);
        for (int k = 0; k < 4; k++) c_set_rd(k, k + 1);
        expect_val("c_bvec_r3", 64'h0008);
        expect_val("c_retire_rdbusy", 64'd0);
        #2;
        compare_next(c_busy_vec);
        compare_next(c_rd_busy);
        @(negedge clk);
        idle();
        expect_val("c_p0", P1);
        expect_val("c_p1", P2);
        expect_val("c_p2", P3);
        expect_val("c_p3", P4);
        #2;
        for (int k = 0; k < 4; k++) compare_next(c_rd_data[k*XLC +: XLC]);
        @(negedge clk);
        c_set_rd(0, 2); c_set_rd(1, 1); c_set_rd(2, 2); c_set_rd(3, 4);
        c_wr(0, 2, P5);
        expect_val("c_byp_p0", P5);
        expect_val("c_p1_r1", P1);
        expect_val("c_byp_p2", P5);
        expect_val("c_p3_r4", P4);
        #2;
        for (int k = 0; k < 4; k++) compare_next(c_rd_data[k*XLC +: XLC]);

        // Randomised run on A against a behavioural model
        @(negedge clk);
        idle(); rst_n = 1'b0;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            wr_en = 2'($urandom_range(0, 3));
            wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data = {$urandom(), $urandom()};
            issue_en = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            for (int k = 0; k < 2; k++) begin
                expect_val("rnd_data", 64'(m_read(rd_addr[k*AW +: AW])));
                expect_val("rnd_rdbusy", 64'(m_rdbusy(rd_addr[k*AW +: AW])));
            end
            expect_val("rnd_bvec", 64'(m_busy));
            #2;
            for (int k = 0; k < 2; k++) begin
                compare_next(a_rd_data[k*XL +: XL]);
                compare_next(a_rd_busy[k]);
            end
            compare_next(a_busy_vec);
            for (int r = 1; r < 32; r++) begin
                if (wr_en[1] && wr_addr[9:5] == 5'(r)) m_regs[r] = wr_data[63:32];
                else if (wr_en[0] && wr_addr[4:0] == 5'(r)) m_regs[r] = wr_data[31:0];
                if (issue_en && issue_addr == 5'(r)) m_busy[r] = 1'b1;
                else if ((wr_en[0] && wr_addr[4:0] == 5'(r)) || (wr_en[1] && wr_addr[9:5] == 5'(r)))
                    m_busy[r] = 1'b0;
            end
        end
        @(negedge clk);
        idle();

        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core; successor to the single-write/two-read file.
- Adds configurable width, depth and read-port count, a second write port, write-to-read bypass on both write ports, asynchronous reset of all state, and a per-register busy scoreboard.
- The scoreboard lets decode detect RAW hazards against in-flight producers.
- Sits between decode (reads, issue) and writeback (two retire lanes).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy; when 0 register 0 is an ordinary register.
- Derived: AW = $clog2(NREGS).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational, bypassed.
- rd_busy  out  NRD  busy flag of each read address, combinational.
- wr_en  in  2  write enables, lane 0 and lane 1.
- wr_addr  in  2*AW  packed write addresses.
- wr_data  in  2*XLEN  packed write data.
- issue_en  in  1  marks issue_addr as having a pending producer.
- issue_addr  in  AW  destination of the newly issued instruction.
- busy_vec  out  NREGS  full scoreboard state, registered.

Behaviour:
- Reset: reset_n low clears all registers and all busy bits to 0 immediately, without waiting for a clock edge.
  - While reset_n is low, rd_data reads 0 unless bypassed, rd_busy=0 and busy_vec=0.
  - Write enables and issue_en are ignored while reset_n is low.
- Write: on a rising edge, for each lane i with wr_en[i]=1, register wr_addr[i] <= wr_data[i]. Write latency is 1 cycle.
- Dual write, same address: lane 1 wins. Different addresses: both writes commit.
- Read: for each port k, rd_data[k] is selected in priority order:
  - lane 1 bypass: wr_en[1] and wr_addr[1]==rd_addr[k] -> wr_data[1];
  - lane 0 bypass: the same test on lane 0 -> wr_data[0];
  - otherwise the stored register value.
  - There is zero read latency, including same-cycle write-through.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - reads of address 0 return 0 with no bypass;
  - issue to address 0 is ignored;
  - busy_vec[0] is always 0.
- Scoreboard: busy[r] is a flop per register. On each rising edge, for each r:
  - set = issue_en and issue_addr==r;
  - clr = (wr_en[0] and wr_addr[0]==r) or (wr_en[1] and wr_addr[1]==r);
  - busy[r] <= set ? 1 : (clr ? 0 : busy[r]).
  - Set wins over clear in the same cycle: the new producer supersedes the retiring one.
- rd_busy[k] = busy[rd_addr[k]] and not clr(rd_addr[k]).
  - A register retiring this cycle reads as not busy, consistent with the bypassed data.
  - A same-cycle issue does not affect rd_busy until the next cycle.
- Issuing to an already-busy register keeps it busy. No counting: a single write clears it.
- Writes to a non-busy register are legal: data updates and busy stays 0.
- Out-of-range addresses (NREGS not a power of two) are not supported.
- All combinational outputs depend only on the current inputs and state; there are no combinational loops from outputs to inputs.

Test Plan:
- Reset: write 0xDEADBEEF to r5, issue r7, then pull reset_n low mid-cycle -> r5 reads 0 and busy_vec==0 before the next edge; after release r5 still reads 0.
- Bypass priority: wr_en=2'b11, both lanes to r3 (lane0 0x1111, lane1 0x2222), rd_addr port0=r3 -> rd_data0=0x2222 in the same cycle and r3 holds 0x2222 afterwards.
  - Lane0 alone to r3 with 0x1111 -> same-cycle read 0x1111.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 with issue_en on r0 -> rd_data=0 on all ports and busy_vec[0]=0.
  - With ZERO_REG=0, the same stimulus -> r0 reads 0xFFFFFFFF and busy_vec[0]=1.
- Scoreboard: issue r9 at cycle t -> busy_vec[9]=1 from t+1; lane0 write r9=0x42 at t+3 -> rd_busy=0 and rd_data=0x42 combinationally at t+3, busy_vec[9]=0 at t+4.
  - Issue r9 and lane1 write r9 in the same cycle -> busy_vec[9] stays 1.
- Parametrisation: XLEN=64, NREGS=16, NRD=4; all four ports read distinct registers r1..r4 after writing 64-bit patterns -> each port returns its own pattern; two ports reading the address being written both see the bypassed value.
